// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register with MIPS32 field decode.
// One entry of storage between fetch and execute; the registered word is
// split into register fields, immediate and jump target, and the extension
// mode for the BitExtender is derived from the opcode.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. valid must not depend on ready; ready here is
// in_ready = ~out_valid | out_ready (no flush term). While out_valid is high
// and out_ready is low, every registered value holds.
module decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] pc_out,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] target26,
   output logic        ext_zero,
   output logic        is_rtype
);

   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        valid_q;
   logic        load;

   // Stage is free when empty or when its current word leaves this cycle.
   assign in_ready = ~valid_q | out_ready;
   assign load     = in_valid & in_ready;

   // Pipeline register: reset, then flush, then load, then plain consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= 32'h0000_0000;
         pc_q    <= RESET_PC;
      end else if (flush) begin
         // Squash both the held word and whatever fetch offers this edge.
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         instr_q <= in_instr;
         pc_q    <= in_pc;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Field decode straight off the registered word; no look-ahead on in_instr.
   always_comb begin
      out_valid = valid_q;
      // RESET_PC stands in for the PC whenever no instruction is held.
      pc_out    = valid_q ? pc_q : RESET_PC;
      opcode    = instr_q[31:26];
      rs        = instr_q[25:21];
      rt        = instr_q[20:16];
      rd        = instr_q[15:11];
      shamt     = instr_q[10:6];
      funct     = instr_q[5:0];
      imm16     = instr_q[15:0];
      target26  = instr_q[25:0];
      // andi/ori/xori/lui (0x0C..0x0F) zero-extend; everything else sign-extends.
      ext_zero  = (instr_q[31:26] == 6'h0C) || (instr_q[31:26] == 6'h0D) ||
                  (instr_q[31:26] == 6'h0E) || (instr_q[31:26] == 6'h0F);
      is_rtype  = (instr_q[31:26] == 6'h00);
   end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: scoreboard of {pc, instr} words pushed when the
// bench hands a word to the stage and popped when execute consumes it.
module tb_decode_stage;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] target26;
   logic        ext_zero;
   logic        is_rtype;

   logic [63:0] exp_q[$];
   int          n_checks;
   int          n_errors;

   decode_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .imm16(imm16), .target26(target26),
      .ext_zero(ext_zero), .is_rtype(is_rtype)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bitext(input logic [15:0] imm, input logic zero);
      bitext = zero ? {16'h0000, imm} : {{16{imm[15]}}, imm};
   endfunction

   // Compare every decoded output against a word the bench expects.
   task automatic check_word(input logic [63:0] w);
      logic [31:0] ins;
      logic [31:0] pc;
      logic        ez;
      pc  = w[63:32];
      ins = w[31:0];
      case (ins[31:26])
         6'h0C, 6'h0D, 6'h0E, 6'h0F: ez = 1'b1;
         default:                    ez = 1'b0;
      endcase
      check("pc_out",   pc_out,   pc);
      check("opcode",   opcode,   ins[31:26]);
      check("rs",       rs,       ins[25:21]);
      check("rt",       rt,       ins[20:16]);
      check("rd",       rd,       ins[15:11]);
      check("shamt",    shamt,    ins[10:6]);
      check("funct",    funct,    ins[5:0]);
      check("imm16",    imm16,    ins[15:0]);
      check("target26", target26, ins[25:0]);
      check("ext_zero", ext_zero, ez);
      check("is_rtype", is_rtype, ins[31:26] == 6'h00);
      check("bitext",   bitext(imm16, ext_zero), bitext(ins[15:0], ez));
   endtask

   // driver: one clock cycle; called just after a rising edge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic r);
      logic exp_valid;
      logic exp_ready;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      @(negedge clk);
      exp_valid = (exp_q.size() != 0);
      exp_ready = ~exp_valid | ordy;
      check("out_valid", out_valid, exp_valid);
      check("in_ready",  in_ready,  exp_ready);
      if (exp_valid) check_word(exp_q[0]);
      if (r || fl) begin
         exp_q.delete();
      end else begin
         if (exp_valid && ordy) void'(exp_q.pop_front());
         if (v && exp_ready) exp_q.push_back({pc, ins});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 32'hDEAD_BEEF, 32'h0, ordy, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_pc     = 32'h0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Reset for two cycles.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_pc_out",    pc_out,    RESET_PC);
      check("rst_ext_zero",  ext_zero,  1'b0);
      check("rst_is_rtype",  is_rtype,  1'b1);
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_opcode",    opcode,    6'h00);
      check("rst_imm16",     imm16,     16'h0000);
      @(posedge clk);
      #1;

      // ori $8,$0,0x8000: zero-extended immediate.
      cycle(1'b1, 32'h3408_8000, 32'h0040_0000, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      check("ori_opcode", opcode, 6'h0D);
      check("ori_rt",     rt,     5'd8);
      check("ori_ext",    bitext(imm16, ext_zero), 32'h0000_8000);
      idle(1'b1);

      // addi $8,$0,-1: sign-extended immediate.
      cycle(1'b1, 32'h2008_FFFF, 32'h0040_0004, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      check("addi_ext_zero", ext_zero, 1'b0);
      check("addi_ext",      bitext(imm16, ext_zero), 32'hFFFF_FFFF);
      idle(1'b1);

      // Stall three cycles with changing fetch words, then release.
      cycle(1'b1, 32'h012A_4020, 32'h0040_0100, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h1000_0000 + i, 32'h0040_0200 + 4 * i, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h8D09_0010, 32'h0040_0104, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Stream eight instructions back to back.
      for (int i = 0; i < 8; i++)
         cycle(1'b1, $urandom, 32'h0040_1000 + 4 * i, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Flush with both a held and an incoming word.
      cycle(1'b1, 32'h3C01_1234, 32'h0040_2000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h3021_5678, 32'h0040_2004, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // Reset while stalled drops the entry.
      cycle(1'b1, 32'hAC22_0008, 32'h0040_3000, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      cycle(1'b1, 32'h1111_1111, 32'h0040_3004, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("rst_stall_valid", out_valid, 1'b0);
      check("rst_stall_pc",    pc_out,    RESET_PC);
      @(posedge clk);
      #1;

      // Random traffic with occasional flush.
      for (int i = 0; i < 60; i++)
         cycle($urandom_range(0, 1), $urandom, 32'h0050_0000 + 4 * i,
               $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'b0);

      // Drain.
      repeat (3) idle(1'b1);
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
